// File: rtl/fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fetch_unit                                                              |
// | Instruction fetch front end: PC, credit-limited memory reads, in-order  |
// | instruction queue and redirect flush.                                   |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w:0]   c_depth   = (c_cnt_w + 1)'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_resp_pc;
    logic [c_cnt_w-1:0] r_inflight;
    logic [c_cnt_w-1:0] r_drop;
    logic [c_cnt_w-1:0] r_count;
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [31:0]        r_q_word [DEPTH];
    logic [31:0]        r_q_pc   [DEPTH];

    logic               w_accept;
    logic               w_resp;
    logic               w_push;
    logic               w_pop;
    logic [c_cnt_w:0]   w_occupancy;
    logic [c_cnt_w-1:0] w_inflight_nxt;
    logic [31:0]        w_redirect_addr;
    logic               w_unused_pc_bits;

    // Credit covers both outstanding reads and buffered words, so a push never overflows.
    assign w_occupancy      = {1'b0, r_inflight} + {1'b0, r_count};
    assign imem_req         = reset_n && !redirect_valid && (w_occupancy < c_depth);
    assign imem_addr        = r_fetch_pc;
    assign w_accept         = imem_req && imem_ready;
    assign w_resp           = imem_rvalid && (r_inflight != '0);
    assign w_push           = w_resp && (r_drop == '0) && !redirect_valid;
    assign w_pop            = instr_valid && instr_ready;
    assign w_redirect_addr  = {redirect_pc[31:2], 2'b00};
    assign w_unused_pc_bits = ^redirect_pc[1:0];

    assign instr_valid = (r_count != '0);
    assign instr       = r_q_word[r_head];
    assign instr_pc    = r_q_pc[r_head];

    always_comb begin
        w_inflight_nxt = r_inflight;
        if (w_accept) w_inflight_nxt = w_inflight_nxt + c_cnt_one;
        if (w_resp)   w_inflight_nxt = w_inflight_nxt - c_cnt_one;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_inflight <= '0;
            r_drop     <= '0;
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_word[i] <= '0;
                r_q_pc[i]   <= RESET_PC;
            end
        end else if (redirect_valid) begin
            // Everything still outstanding after this cycle belongs to the old path.
            r_fetch_pc <= w_redirect_addr;
            r_resp_pc  <= w_redirect_addr;
            r_inflight <= w_inflight_nxt;
            r_drop     <= w_inflight_nxt;
            r_count    <= '0;
            r_tail     <= r_head;
        end else begin
            r_inflight <= w_inflight_nxt;
            if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
            if (w_resp && (r_drop != '0)) r_drop <= r_drop - c_cnt_one;
            if (w_push) begin
                r_q_word[r_tail] <= imem_rdata;
                r_q_pc[r_tail]   <= r_resp_pc;
                r_tail           <= r_tail + c_ptr_one;
                r_resp_pc        <= r_resp_pc + 32'd4;
            end
            if (w_pop) r_head <= r_head + c_ptr_one;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_fetch_unit                                                           |
// | Randomized scoreboard bench for fetch_unit with an in-order memory.     |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int          DEPTH    = 2;

    logic        clock = 1'b0;
    logic        reset_n, imem_req, imem_ready, imem_rvalid;
    logic        redirect_valid, instr_valid, instr_ready;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;

    always #5 clock = ~clock;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready)
    );

    typedef struct packed { logic [31:0] addr; int epoch; int due; } mreq_t;
    typedef struct packed { logic [31:0] pc; logic [31:0] word; } exp_t;

    mreq_t       mem_q[$];
    exp_t        exp_q[$];
    logic [31:0] acc_addr[$];
    int          checks = 0, failures = 0;
    int          cyc = 0, epoch = 0, orphan_n = 0, n_acc = 0, n_instr = 0;
    logic [31:0] fetch_pc_m = RESET_PC;

    int          p_ready = 0, p_rv = 100, p_ir = 100, p_redir = 0, lat_min = 1, lat_max = 1;
    bit          rst_req = 1'b1, force_redir = 1'b0, force_redir_rv = 1'b0;
    bit          orphan_en = 1'b0, chk_en = 1'b0, redir_seen = 1'b0;
    logic [31:0] force_pc = 32'h0;
    bit          cur_orphan, pend;
    exp_t        pend_e;
    mreq_t       r;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model + stimulus driver + reference bookkeeping, one cycle per pass.
    initial begin
        reset_n = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        forever begin
            @(posedge clock); #1;
            cyc++;
            reset_n     = !rst_req;
            imem_ready  = ($urandom_range(99) < p_ready);
            instr_ready = ($urandom_range(99) < p_ir);
            imem_rvalid = 1'b0; imem_rdata = $urandom; cur_orphan = 1'b0;
            if (orphan_en && orphan_n > 0) begin
                imem_rvalid = 1'b1; cur_orphan = 1'b1;
            end else if (reset_n && mem_q.size() > 0 && mem_q[0].due <= cyc &&
                         $urandom_range(99) < p_rv) begin
                imem_rvalid = 1'b1; imem_rdata = word_of(mem_q[0].addr);
            end
            redirect_valid = 1'b0; redirect_pc = $urandom;
            if (reset_n) begin
                if (force_redir) begin
                    redirect_valid = 1'b1; redirect_pc = force_pc; force_redir = 1'b0; redir_seen = 1'b1;
                end else if (force_redir_rv && imem_rvalid && instr_valid && instr_ready) begin
                    redirect_valid = 1'b1; force_redir_rv = 1'b0; redir_seen = 1'b1;
                end else if ($urandom_range(99) < p_redir) begin
                    redirect_valid = 1'b1;
                end
            end

            @(negedge clock); #1;
            pend = 1'b0;
            if (!reset_n) begin
                if (chk_en) check("req_in_reset", 32'(imem_req), 32'h0);
                if (imem_rvalid && cur_orphan) orphan_n--;
            end else begin
                if (chk_en) begin
                    check("imem_req", 32'(imem_req),
                          32'(!redirect_valid && (mem_q.size() + exp_q.size()) < DEPTH));
                    check("imem_addr", imem_addr, fetch_pc_m);
                end
                if (imem_req && imem_ready) begin
                    mem_q.push_back('{addr: fetch_pc_m, epoch: epoch,
                                      due: cyc + int'($urandom_range(lat_max, lat_min))});
                    acc_addr.push_back(imem_addr);
                    fetch_pc_m = fetch_pc_m + 32'd4;
                    n_acc++;
                end
                if (imem_rvalid) begin
                    if (cur_orphan) orphan_n--;
                    else begin
                        r = mem_q.pop_front();
                        if (!redirect_valid && r.epoch == epoch) begin
                            pend = 1'b1; pend_e = '{pc: r.addr, word: word_of(r.addr)};
                        end
                    end
                end
            end

            #2;
            if (!reset_n) begin
                orphan_n += mem_q.size();
                mem_q.delete(); exp_q.delete();
                fetch_pc_m = RESET_PC; epoch++;
            end else if (redirect_valid) begin
                exp_q.delete(); epoch++;
                fetch_pc_m = {redirect_pc[31:2], 2'b00};
            end else if (pend) begin
                exp_q.push_back(pend_e);
            end
        end
    end

    // Monitor: compares the presented head against the scoreboard.
    initial forever begin
        @(negedge clock); #2;
        if (chk_en) begin
            check("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
            if (instr_valid && exp_q.size() != 0) begin
                check("instr_pc", instr_pc, exp_q[0].pc);
                check("instr", instr, exp_q[0].word);
                if (instr_ready) begin
                    void'(exp_q.pop_front());
                    n_instr++;
                end
            end
        end
    end

    task automatic settle();
        @(negedge clock); #4;
    endtask

    task automatic do_reset();
        p_ready = 0; p_redir = 0; rst_req = 1'b1; orphan_en = 1'b1;
        repeat (2) @(posedge clock);
        rst_req = 1'b0; chk_en = 1'b1;
        for (int i = 0; i < 20 && orphan_n > 0; i++) @(posedge clock);
        check("orphan_drain", 32'(orphan_n), 32'h0);
        orphan_en = 1'b0;
        acc_addr.delete(); n_acc = 0;
    endtask

    task automatic wait_inflight2();
        for (int i = 0; i < 40 && mem_q.size() != 2; i++) @(posedge clock);
        check("two_inflight", 32'(mem_q.size()), 32'h2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        // Reset state, then memory stalled for 5 cycles.
        settle();
        check("rst_instr_valid", 32'(instr_valid), 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, RESET_PC);
        check("rst_imem_addr", imem_addr, RESET_PC);
        for (int i = 0; i < 5; i++) begin
            settle();
            check("stall_req", 32'(imem_req), 32'h1);
            check("stall_addr", imem_addr, RESET_PC);
            check("stall_valid", 32'(instr_valid), 32'h0);
        end
        check("stall_no_accept", 32'(n_acc), 32'h0);

        // Streaming at latency 1.
        @(posedge clock);
        p_ready = 100; lat_min = 1; lat_max = 1; p_rv = 100; p_ir = 100; n_instr = 0;
        repeat (30) @(posedge clock);
        check("stream_progress", 32'(n_instr >= 15), 32'h1);
        check("stream_first_addr", (acc_addr.size() > 0) ? acc_addr[0] : 32'hX, RESET_PC);

        // Decode back-pressure: credit stops at DEPTH.
        do_reset();
        p_ready = 100; p_ir = 0;
        repeat (8) @(posedge clock);
        settle();
        check("bp_accepts", 32'(n_acc), 32'h2);
        check("bp_req", 32'(imem_req), 32'h0);
        check("bp_valid", 32'(instr_valid), 32'h1);
        check("bp_pc", instr_pc, RESET_PC);
        check("bp_word", instr, word_of(RESET_PC));
        @(posedge clock);
        p_ir = 100;
        repeat (10) @(posedge clock);
        check("bp_resume_addr", (acc_addr.size() > 2) ? acc_addr[2] : 32'hX, RESET_PC + 32'h8);

        // Redirect with two stale reads at latency 3.
        do_reset();
        p_ready = 100; lat_min = 3; lat_max = 3; p_ir = 100;
        wait_inflight2();
        force_pc = 32'h0000_2003; redir_seen = 1'b0; force_redir = 1'b1;
        for (int i = 0; i < 10 && !redir_seen; i++) @(posedge clock);
        check("redir_issued", 32'(redir_seen), 32'h1);
        settle();
        check("redir_valid_drop", 32'(instr_valid), 32'h0);
        for (int i = 0; i < 30 && !instr_valid; i++) settle();
        check("redir_pc", instr_pc, 32'h0000_2000);
        check("redir_word", instr, word_of(32'h0000_2000));

        // Redirect coinciding with a response and a pop.
        @(posedge clock);
        lat_min = 1; lat_max = 1; redir_seen = 1'b0; force_redir_rv = 1'b1;
        for (int i = 0; i < 40 && !redir_seen; i++) @(posedge clock);
        check("redir_rv_issued", 32'(redir_seen), 32'h1);
        settle();
        check("redir_rv_valid", 32'(instr_valid), 32'h0);
        @(posedge clock);
        force_redir_rv = 1'b0;
        repeat (20) @(posedge clock);

        // Reset with two reads outstanding; late responses must be ignored.
        lat_min = 4; lat_max = 4;
        wait_inflight2();
        do_reset();
        settle();
        check("mid_rst_valid", 32'(instr_valid), 32'h0);
        check("mid_rst_addr", imem_addr, RESET_PC);
        @(posedge clock);
        p_ready = 100; lat_min = 1; lat_max = 2;
        repeat (20) @(posedge clock);
        check("mid_rst_restart", (acc_addr.size() > 0) ? acc_addr[0] : 32'hX, RESET_PC);

        // Randomized traffic.
        p_ready = 70; lat_min = 1; lat_max = 4; p_rv = 80; p_ir = 60; p_redir = 4;
        repeat (3000) @(posedge clock);
        p_redir = 0; p_ir = 100; p_ready = 100; p_rv = 100;
        repeat (40) @(posedge clock);
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
